// File: rtl/piso_tx_sched_pkg.sv
// piso_tx_sched_pkg
//   Shared types and build-time constants for the PISO transmit scheduler.
//
//   Build option:
//     PISO_TX_SCHED_PARITY_EN - when defined, an even-parity bit is appended
//                               after the data bits of every word.
//
//   Contents:
//     state_t    - scheduler FSM states (IDLE, SHIFT, PARITY)
//     PARITY_EN  - 1 when the parity build option is enabled, else 0

package piso_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

`ifdef PISO_TX_SCHED_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

endpackage : piso_tx_sched_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with an internal priority pointer.  The search for a
//   winner starts one past the last granted index and wraps modulo NUM_REQ.
//   The pointer only moves when the caller reports an actual transfer, so a
//   grant that is not taken does not cost the requester its turn.
//
//   Parameters:
//     NUM_REQ - number of requesters (2..16)
//     IDX_W   - width of the grant index
//
//   Ports:
//     clk    in   clock
//     resetn in   asynchronous active-low reset (requester 0 gets top priority)
//     req    in   NUM_REQ request vector
//     en     in   allow a grant this cycle; grant is all-zero when low
//     adv    in   a transfer happened on the current grant; move the pointer
//     grant  out  one-hot grant (combinational)
//     idx    out  binary index of the granted requester (combinational)

module rr_arbiter
  import piso_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Index of the most recent winner; the search begins just after it.
  logic [IDX_W-1:0] ptr_p1;

  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr_p1) + 1 + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

  // Pointer reset to the last index so the first search starts at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_p1 <= IDX_W'(NUM_REQ - 1);
    end else if (adv) begin
      ptr_p1 <= idx;
    end
  end

endmodule : rr_arbiter

// File: rtl/piso_tx_sched.sv
// piso_tx_sched
//   Round-robin scheduler and sequencer for the parallel-in/serial-out shift
//   path.  Picks one of NUM_REQ word producers, loads its word into the shift
//   register and sends it LSB-first on dout with valid, last and source tags.
//   A new word can be accepted during the final cycle of the current one, so
//   back-to-back words leave no gap on the serial line.
//
//   Build option:
//     PISO_TX_SCHED_PARITY_EN - append one even-parity (XOR) bit per word in a
//                               PARITY cycle; dout_last moves to that cycle and
//                               the accept window moves with it.
//
//   Parameters:
//     DATA_WIDTH - width of each parallel word
//     NUM_REQ    - number of requesters (2..16)
//     SRC_W      - width of the source index
//
//   Ports:
//     clk        in   rising-edge clock
//     resetn     in   asynchronous active-low reset
//     req_valid  in   per-requester word valid
//     req_data   in   packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready  out  one-hot grant; transfer when req_valid[i] & req_ready[i]
//     ser_hold   in   downstream stall, freezes shifting and blocks grants
//     dout       out  serial bit
//     dout_valid out  dout carries a bit this cycle
//     dout_last  out  final bit of the current word
//     dout_src   out  requester index of the word being shifted
//     busy       out  scheduler is not idle

module piso_tx_sched
  import piso_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          ser_hold,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          dout_last,
  output logic [SRC_W-1:0]              dout_src,
  output logic                          busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

`ifdef PISO_TX_SCHED_PARITY_EN
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  state_t                  state_p1;
  logic [DATA_WIDTH-1:0]   shreg_p1;
  logic [CNT_W-1:0]        cnt_p1;
  logic [SRC_W-1:0]        src_p1;
`ifdef PISO_TX_SCHED_PARITY_EN
  logic                    par_p1;
`endif

  logic                    at_last_bit;
  logic                    accept_win;
  logic                    arb_en;
  logic                    transfer;
  logic [NUM_REQ-1:0]      grant;
  logic [SRC_W-1:0]        gidx;
  logic [DATA_WIDTH-1:0]   word_p0;
  logic                    vld_p1;

  // ---- stage p0: arbitration and word selection ----
  // Without parity the last data bit is the hand-off cycle; with parity the
  // PARITY cycle is.  ser_hold blocks every grant so the line never advances
  // while the driver is stalled.
  assign at_last_bit = (state_p1 == SHIFT) && (cnt_p1 == CNT_LAST);
  assign accept_win  = (state_p1 == IDLE)
                     || (!PARITY_EN && at_last_bit)
                     || (state_p1 == PARITY);
  assign arb_en      = accept_win && !ser_hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req_valid),
    .en     (arb_en),
    .adv    (transfer),
    .grant  (grant),
    .idx    (gidx)
  );

  // req_ready depends on req_valid and state only; req_data feeds registers.
  assign req_ready = grant;
  assign transfer  = |(req_valid & grant);
  assign word_p0   = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

  // ---- stage p1: shift register, bit counter, FSM ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p1 <= IDLE;
      shreg_p1 <= '0;
      cnt_p1   <= '0;
      src_p1   <= '0;
    end else if (!ser_hold) begin
      if (transfer) begin
        shreg_p1 <= word_p0;
        cnt_p1   <= '0;
        src_p1   <= gidx;
        state_p1 <= SHIFT;
      end else begin
        case (state_p1)
          SHIFT: begin
            shreg_p1 <= shreg_p1 >> 1;
            if (cnt_p1 == CNT_LAST) begin
              cnt_p1   <= '0;
`ifdef PISO_TX_SCHED_PARITY_EN
              state_p1 <= PARITY;
`else
              state_p1 <= IDLE;
`endif
            end else begin
              cnt_p1 <= cnt_p1 + 1'b1;
            end
          end
`ifdef PISO_TX_SCHED_PARITY_EN
          PARITY: state_p1 <= IDLE;
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef PISO_TX_SCHED_PARITY_EN
  // Parity is taken from the word as loaded, not recomputed while shifting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_p1 <= 1'b0;
    end else if (!ser_hold && transfer) begin
      par_p1 <= even_parity(word_p0);
    end
  end
`endif

  // ---- output decode from p1 registers ----
  assign vld_p1 = (state_p1 != IDLE);

  always_comb begin
    dout      = 1'b0;
    dout_last = 1'b0;
    case (state_p1)
      SHIFT: begin
        dout      = shreg_p1[0];
        dout_last = !PARITY_EN && (cnt_p1 == CNT_LAST);
      end
`ifdef PISO_TX_SCHED_PARITY_EN
      PARITY: begin
        dout      = par_p1;
        dout_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign dout_valid = vld_p1;
  assign busy       = vld_p1;
  assign dout_src   = src_p1;

endmodule : piso_tx_sched

// File: tb/tb_piso_tx_sched.sv
module tb_piso_tx_sched;

  localparam int DW = 8;
`ifdef PISO_TX_SCHED_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WLEN = DW + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // DUT A: NUM_REQ = 2
  logic [1:0]      valid_a;
  logic [2*DW-1:0] data_a;
  logic [1:0]      ready_a;
  logic            hold_a;
  logic            dout_a, dv_a, dl_a, busy_a;
  logic [0:0]      src_a;

  // DUT B: NUM_REQ = 4
  logic [3:0]      valid_b;
  logic [4*DW-1:0] data_b;
  logic [3:0]      ready_b;
  logic            hold_b;
  logic            dout_b, dv_b, dl_b, busy_b;
  logic [1:0]      src_b;

  piso_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(2), .SRC_W(1)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .ser_hold(hold_a), .dout(dout_a), .dout_valid(dv_a),
    .dout_last(dl_a), .dout_src(src_a), .busy(busy_a));

  piso_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(4), .SRC_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .ser_hold(hold_b), .dout(dout_b), .dout_valid(dv_b),
    .dout_last(dl_b), .dout_src(src_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard entries: {bit, last, src[3:0]}
  logic [5:0] sb[$];
  int glog_a[$];
  int glog_b[$];
  int cyc = 0;
  int vcount, first_cyc, last_cyc, lastcount;
  logic [DW-1:0] w_cap;

  task automatic clear_stats();
    vcount    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    lastcount = 0;
  endtask

  // Input side: each accepted word becomes its expected bit sequence.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_a[i] && ready_a[i]) begin
          w_cap = data_a[i*DW +: DW];
          glog_a.push_back(i);
          for (int k = 0; k < DW; k++)
            sb.push_back({w_cap[k], 1'((k == DW-1) && (PAR == 0)), 4'(i)});
          if (PAR != 0) sb.push_back({^w_cap, 1'b1, 4'(i)});
        end
      end
      for (int i = 0; i < 4; i++)
        if (valid_b[i] && ready_b[i]) glog_b.push_back(i);
    end
  end

  // Output side: compare every valid bit; a held cycle must repeat the same bit.
  always @(negedge clk) begin
    cyc++;
    if (resetn === 1'b1) begin
      if (dv_a) begin
        vcount++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (dl_a) lastcount++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bit: got dout=%0b with nothing expected, required no valid", dout_a);
        end else begin
          chk("bit_stream", {26'd0, dout_a, dl_a, 3'b000, src_a}, {26'd0, sb[0]});
          if (!hold_a) void'(sb.pop_front());
        end
      end else begin
        chk("idle_dout", {31'd0, dout_a}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn  = 1'b0;
    valid_a = '0;
    valid_b = '0;
    hold_a  = 1'b0;
    hold_b  = 1'b0;
    sb.delete();
    glog_a.delete();
    glog_b.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_stats();
  endtask

  // Returns at the posedge on which the n-th A transfer is taken.
  task automatic wait_hs_a(input int n);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (glog_a.size() < n && t < 200);
    if (glog_a.size() < n) begin
      total++;
      bad++;
      $display("FAIL hs_a_timeout: got %0d transfers, required %0d", glog_a.size(), n);
    end
  endtask

  task automatic wait_hs_b(input int n);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (glog_b.size() < n && t < 200);
    if (glog_b.size() < n) begin
      total++;
      bad++;
      $display("FAIL hs_b_timeout: got %0d transfers, required %0d", glog_b.size(), n);
    end
  endtask

  task automatic wait_idle_a();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((dv_a !== 1'b0 || sb.size() != 0) && t < 300);
    if (dv_a !== 1'b0 || sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL idle_a_timeout: got %0d bits pending, required 0", sb.size());
    end
  endtask

  function automatic int glog_at(input int k);
    return (glog_a.size() > k) ? glog_a[k] : -1;
  endfunction

  function automatic int glogb_at(input int k);
    return (glog_b.size() > k) ? glog_b[k] : -1;
  endfunction

  initial begin
    resetn  = 1'b0;
    valid_a = '0;
    valid_b = '0;
    data_a  = '0;
    data_b  = '0;
    hold_a  = 1'b0;
    hold_b  = 1'b0;
    clear_stats();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout",  {31'd0, dout_a}, 32'd0);
    chk("rst_valid", {31'd0, dv_a},   32'd0);
    chk("rst_last",  {31'd0, dl_a},   32'd0);
    chk("rst_busy",  {31'd0, busy_a}, 32'd0);
    chk("rst_src",   {31'd0, src_a},  32'd0);
    chk("rst_ready", {30'd0, ready_a}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Single word 8'hA5 from requester 0
    do_reset();
    data_a[7:0] = 8'hA5;
    valid_a     = 2'b01;
    @(negedge clk);
    chk("a5_ready_same_cycle", {30'd0, ready_a}, 32'd1);
    wait_hs_a(1);
    #1 valid_a = '0;
    wait_idle_a();
    chk("a5_word_len",  vcount, WLEN);
    chk("a5_last_once", lastcount, 1);
    chk("a5_grant",     glog_at(0), 0);

    // Both requesters continuously valid: alternate, no bubbles
    do_reset();
    data_a  = {8'h00, 8'hFF};
    valid_a = 2'b11;
    wait_hs_a(4);
    #1 valid_a = '0;
    wait_idle_a();
    chk("b2b_valid_cycles", vcount, 4*WLEN);
    chk("b2b_contiguous",   last_cyc - first_cyc + 1, 4*WLEN);
    chk("b2b_last_count",   lastcount, 4);
    chk("b2b_grant0", glog_at(0), 0);
    chk("b2b_grant1", glog_at(1), 1);
    chk("b2b_grant2", glog_at(2), 0);
    chk("b2b_grant3", glog_at(3), 1);

    // ser_hold for 3 cycles at bit 4 of 8'h3C (bit 4 = 1)
    do_reset();
    data_a  = {8'h00, 8'h3C};
    valid_a = 2'b01;
    wait_hs_a(1);
    #1 valid_a = '0;
    repeat (4) @(posedge clk);
    #1;
    hold_a  = 1'b1;
    valid_a = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_ready", {30'd0, ready_a}, 32'd0);
      chk("hold_dout_bit4", {31'd0, dout_a}, 32'd1);
      @(posedge clk);
    end
    #1;
    hold_a  = 1'b0;
    valid_a = '0;
    wait_idle_a();
    chk("hold_word_cycles", vcount, WLEN + 3);
    chk("hold_contiguous",  last_cyc - first_cyc + 1, WLEN + 3);
    chk("hold_last_once",   lastcount, 1);

    // Reset in the middle of a word from requester 1
    do_reset();
    data_a  = {8'h5A, 8'hC3};
    valid_a = 2'b10;
    wait_hs_a(1);
    #1 valid_a = '0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("arst_dout",  {31'd0, dout_a}, 32'd0);
    chk("arst_valid", {31'd0, dv_a},   32'd0);
    chk("arst_last",  {31'd0, dl_a},   32'd0);
    chk("arst_busy",  {31'd0, busy_a}, 32'd0);
    chk("arst_src",   {31'd0, src_a},  32'd0);
    chk("arst_no_last_seen", lastcount, 0);
    glog_a.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_stats();
    valid_a = 2'b11;
    @(negedge clk);
    chk("arst_prio_ready", {30'd0, ready_a}, 32'd1);
    wait_hs_a(1);
    #1 valid_a = '0;
    wait_idle_a();
    chk("arst_prio_grant", glog_at(0), 0);
    chk("arst_word_len",   vcount, WLEN);

    // Word 8'h07 (odd weight, parity bit 1 when enabled)
    do_reset();
    data_a  = {8'h00, 8'h07};
    valid_a = 2'b01;
    wait_hs_a(1);
    #1 valid_a = '0;
    wait_idle_a();
    chk("w07_word_len",  vcount, WLEN);
    chk("w07_last_once", lastcount, 1);

    // Four requesters: 1, then 3 alone, then 0 and 2 together
    do_reset();
    data_b  = {8'h44, 8'h33, 8'h22, 8'h11};
    valid_b = 4'b0010;
    wait_hs_b(1);
    #1 valid_b = 4'b1000;
    wait_hs_b(2);
    #1 valid_b = 4'b0101;
    wait_hs_b(3);
    #1 valid_b = 4'b0100;
    wait_hs_b(4);
    #1 valid_b = '0;
    chk("rr4_grant0", glogb_at(0), 1);
    chk("rr4_grant1", glogb_at(1), 3);
    chk("rr4_grant2", glogb_at(2), 0);
    chk("rr4_grant3", glogb_at(3), 2);
    repeat (WLEN + 2) @(posedge clk);
    @(negedge clk);
    chk("rr4_idle_after", {31'd0, busy_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_piso_tx_sched
